kf8253_bus_master: RTL and testbench

//   Bus initiator that drives KF8253-style PIT bus cycles (CS#/RD#/WR#/A[1:0]/D[7:0]).

---
 rtl/kf8253_bus_master_if.sv | 43 ++++
 rtl/kf8253_bus_master.sv | 228 ++++++++++++++++++++++
 tb/tb_kf8253_bus_master.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kf8253_bus_master_if.sv
// Request/response handshake plus KF8253 PIT bus signals for kf8253_bus_master.
//   master modport : the bus master's view (takes requests, drives the PIT strobes)
//   slave modport  : the host sequencer + PIT view (issues requests, returns read data)
// Signals:
//   req_valid/req_ready       request handshake, accept = valid & ready
//   req_op/counter/rw/mode/bcd/count  request fields
//   done/err/rd_data          completion pulse, error flag and read result
//   pit_*                     CS#/RD#/WR#/A[1:0]/D[7:0] toward the PIT
interface kf8253_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [1:0]  req_counter;
    logic [1:0]  req_rw;
    logic [2:0]  req_mode;
    logic        req_bcd;
    logic [15:0] req_count;
    logic        done;
    logic        err;
    logic [15:0] rd_data;
    logic        pit_chip_select_n;
    logic        pit_read_enable_n;
    logic        pit_write_enable_n;
    logic [1:0]  pit_address;
    logic [7:0]  pit_data_out;
    logic [7:0]  pit_data_in;

    modport master (
        input  req_valid, req_op, req_counter, req_rw, req_mode, req_bcd, req_count,
        input  pit_data_in,
        output req_ready, done, err, rd_data,
        output pit_chip_select_n, pit_read_enable_n, pit_write_enable_n,
        output pit_address, pit_data_out
    );

    modport slave (
        output req_valid, req_op, req_counter, req_rw, req_mode, req_bcd, req_count,
        output pit_data_in,
        input  req_ready, done, err, rd_data,
        input  pit_chip_select_n, pit_read_enable_n, pit_write_enable_n,
        input  pit_address, pit_data_out
    );
endinterface

// File: rtl/kf8253_bus_master.sv
// Bus initiator for a KF8253-style PIT. Accepts one request per handshake and runs it as a
// sequence of byte-wide bus cycles (SETUP -> STROBE -> HOLD -> RECOVER):
//   PROGRAM    : control word to A=3, then count LSB and/or MSB to A=SC
//   LATCH_READ : latch command to A=3, then read LSB and/or MSB from A=SC
// Ports:
//   clock  system clock
//   reset  synchronous, active-high
//   bus    kf8253_bus_master_if.master (request handshake, completion, PIT bus)
// All PIT outputs and done/err/rd_data are registered; they are computed from next state.
module kf8253_bus_master #(
    parameter int unsigned SETUP_CYCLES    = 1,
    parameter int unsigned STROBE_CYCLES   = 2,
    parameter int unsigned HOLD_CYCLES     = 1,
    parameter int unsigned RECOVERY_CYCLES = 1
) (
    input logic                 clock,
    input logic                 reset,
    kf8253_bus_master_if.master bus
);

    localparam logic [7:0] SetupLast    = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] StrobeLast   = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] HoldLast     = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] RecoveryLast = 8'(RECOVERY_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StRecover,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    // Byte index within the request: 0 = control/latch word, 1 = LSB, 2 = MSB.
    logic [1:0]  byte_q, byte_d;

    logic        op_q, op_d;
    logic [1:0]  sc_q, sc_d;
    logic [1:0]  rw_q, rw_d;
    logic [2:0]  mode_q, mode_d;
    logic        bcd_q, bcd_d;
    logic [15:0] count_q, count_d;
    logic        inv_q, inv_d;
    logic [15:0] rd_buf_q, rd_buf_d;

    logic        cs_n_q, cs_n_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic [1:0]  addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] rd_data_q, rd_data_d;

    logic        accept;
    logic        req_invalid;
    logic        phase_last;
    logic        is_read_byte;
    logic [7:0]  ctrl_byte;

    assign bus.req_ready = (state_q == StIdle) && !reset;
    assign accept        = bus.req_valid && bus.req_ready;
    assign req_invalid   = (bus.req_counter == 2'd3) || (bus.req_rw == 2'b00);

    always_comb begin
        phase_last = 1'b0;
        case (state_q)
            StSetup:   phase_last = (cnt_q == SetupLast);
            StStrobe:  phase_last = (cnt_q == StrobeLast);
            StHold:    phase_last = (cnt_q == HoldLast);
            StRecover: phase_last = (cnt_q == RecoveryLast);
            default:   phase_last = 1'b0;
        endcase
    end

    // Next-state: request capture, phase sequencing, read-data sampling.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        byte_d   = byte_q;
        op_d     = op_q;
        sc_d     = sc_q;
        rw_d     = rw_q;
        mode_d   = mode_q;
        bcd_d    = bcd_q;
        count_d  = count_q;
        inv_d    = inv_q;
        rd_buf_d = rd_buf_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d     = bus.req_op;
                    sc_d     = bus.req_counter;
                    rw_d     = bus.req_rw;
                    mode_d   = bus.req_mode;
                    bcd_d    = bus.req_bcd;
                    count_d  = bus.req_count;
                    inv_d    = req_invalid;
                    rd_buf_d = 16'h0000;
                    cnt_d    = 8'd0;
                    byte_d   = 2'd0;
                    state_d  = req_invalid ? StDone : StSetup;
                end
            end
            StSetup, StHold: begin
                if (phase_last) begin
                    cnt_d   = 8'd0;
                    state_d = (state_q == StSetup) ? StStrobe : StRecover;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StStrobe: begin
                if (phase_last) begin
                    cnt_d   = 8'd0;
                    state_d = StHold;
                    // Sample on the edge that ends the strobe, RD# still low.
                    if (op_q && (byte_q == 2'd1)) rd_buf_d[7:0]  = bus.pit_data_in;
                    if (op_q && (byte_q == 2'd2)) rd_buf_d[15:8] = bus.pit_data_in;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StRecover: begin
                if (phase_last) begin
                    cnt_d = 8'd0;
                    // Byte 0 always has a follower since RW=00 is rejected at accept.
                    if (byte_q == 2'd0) begin
                        byte_d  = rw_q[0] ? 2'd1 : 2'd2;
                        state_d = StSetup;
                    end else if ((byte_q == 2'd1) && rw_q[1]) begin
                        byte_d  = 2'd2;
                        state_d = StSetup;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Registered bus outputs, derived from the state being entered.
    always_comb begin
        is_read_byte = op_d && (byte_d != 2'd0);
        ctrl_byte    = op_d ? {sc_d, 6'b00_0000} : {sc_d, rw_d, mode_d, bcd_d};

        cs_n_d = !((state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold));
        wr_n_d = !((state_d == StStrobe) && !is_read_byte);
        rd_n_d = !((state_d == StStrobe) && is_read_byte);

        addr_d = addr_q;
        dout_d = dout_q;
        if (state_d == StSetup) begin
            addr_d = (byte_d == 2'd0) ? 2'd3 : sc_d;
            if (byte_d == 2'd0)      dout_d = ctrl_byte;
            else if (op_d)           dout_d = 8'h00;
            else if (byte_d == 2'd1) dout_d = count_d[7:0];
            else                     dout_d = count_d[15:8];
        end

        done_d    = (state_d == StDone);
        err_d     = (state_d == StDone) && inv_d;
        rd_data_d = rd_data_q;
        if (state_d == StDone) rd_data_d = inv_d ? 16'h0000 : rd_buf_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            byte_q    <= 2'd0;
            op_q      <= 1'b0;
            sc_q      <= 2'd0;
            rw_q      <= 2'd0;
            mode_q    <= 3'd0;
            bcd_q     <= 1'b0;
            count_q   <= 16'h0000;
            inv_q     <= 1'b0;
            rd_buf_q  <= 16'h0000;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            addr_q    <= 2'd0;
            dout_q    <= 8'h00;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            byte_q    <= byte_d;
            op_q      <= op_d;
            sc_q      <= sc_d;
            rw_q      <= rw_d;
            mode_q    <= mode_d;
            bcd_q     <= bcd_d;
            count_q   <= count_d;
            inv_q     <= inv_d;
            rd_buf_q  <= rd_buf_d;
            cs_n_q    <= cs_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.pit_chip_select_n  = cs_n_q;
    assign bus.pit_read_enable_n  = rd_n_q;
    assign bus.pit_write_enable_n = wr_n_q;
    assign bus.pit_address        = addr_q;
    assign bus.pit_data_out       = dout_q;
    assign bus.done               = done_q;
    assign bus.err                = err_q;
    assign bus.rd_data            = rd_data_q;

endmodule

// File: tb/tb_kf8253_bus_master.sv
// Directed bench for kf8253_bus_master: expected bus cycles and completions are queued when a
// request is driven and checked as the PIT strobes and done pulse appear.
module tb_kf8253_bus_master;

    localparam int unsigned S = 1;
    localparam int unsigned T = 2;
    localparam int unsigned H = 1;
    localparam int unsigned R = 1;
    localparam int unsigned CYC = S + T + H + R;

    typedef struct {
        bit         is_rd;
        logic [1:0] addr;
        logic [7:0] data;
    } bus_ev_t;

    typedef struct {
        int          lat;
        logic        err;
        logic [15:0] rd_data;
    } done_ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    kf8253_bus_master_if bus_if ();

    kf8253_bus_master #(
        .SETUP_CYCLES    (S),
        .STROBE_CYCLES   (T),
        .HOLD_CYCLES     (H),
        .RECOVERY_CYCLES (R)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    bus_ev_t    exp_bus[$];
    done_ev_t   exp_done[$];
    logic [7:0] pit_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor and PIT read model.
    int         strobe_run = 0;
    int         cs_run     = 0;
    int         high_run   = 100;
    int         cs_falls   = 0;
    logic       prev_wr    = 1'b1;
    logic       prev_rd    = 1'b1;
    logic       prev_cs    = 1'b1;
    logic [1:0] addr_at_fall;
    logic [7:0] data_at_fall;

    always @(negedge clock) begin
        if (reset) begin
            strobe_run = 0;
            cs_run     = 0;
            high_run   = 100;
            prev_wr    = 1'b1;
            prev_rd    = 1'b1;
            prev_cs    = 1'b1;
            bus_if.pit_data_in = 8'h00;
        end else begin
            bus_ev_t ev;
            if (!bus_if.pit_chip_select_n) begin
                if (prev_cs) begin
                    cs_falls++;
                    check("recovery_width", 32'(high_run >= int'(R)), 32'd1);
                    addr_at_fall = bus_if.pit_address;
                    data_at_fall = bus_if.pit_data_out;
                end
                cs_run++;
                high_run = 0;
            end else begin
                if (cs_run != 0) begin
                    check("cs_low_width", cs_run, S + T + H);
                    check("addr_stable", 32'(bus_if.pit_address), 32'(addr_at_fall));
                    check("data_stable", 32'(bus_if.pit_data_out), 32'(data_at_fall));
                end
                cs_run = 0;
                high_run++;
            end
            if (!bus_if.pit_write_enable_n || !bus_if.pit_read_enable_n) begin
                check("strobe_without_cs", 32'(bus_if.pit_chip_select_n), 32'd0);
                check("single_strobe",
                      32'(bus_if.pit_write_enable_n | bus_if.pit_read_enable_n), 32'd1);
                strobe_run++;
            end else begin
                if (strobe_run != 0) check("strobe_width", strobe_run, T);
                strobe_run = 0;
            end
            if ((!bus_if.pit_write_enable_n && prev_wr) ||
                (!bus_if.pit_read_enable_n && prev_rd)) begin
                check("setup_width", cs_run, S + 1);
                check("strobe_expected", 32'(exp_bus.size() != 0), 32'd1);
                if (exp_bus.size() != 0) begin
                    ev = exp_bus.pop_front();
                    check("strobe_kind", 32'(!bus_if.pit_read_enable_n), 32'(ev.is_rd));
                    check("bus_address", 32'(bus_if.pit_address), 32'(ev.addr));
                    if (!ev.is_rd) check("bus_wdata", 32'(bus_if.pit_data_out), 32'(ev.data));
                end
                if (!bus_if.pit_read_enable_n && (pit_q.size() != 0)) begin
                    bus_if.pit_data_in = pit_q.pop_front();
                end
            end
            prev_wr = bus_if.pit_write_enable_n;
            prev_rd = bus_if.pit_read_enable_n;
            prev_cs = bus_if.pit_chip_select_n;
        end
    end

    // Enter between a posedge and the following negedge; returns at posedge + #1.
    task automatic do_req(input bit op, input logic [1:0] sc, input logic [1:0] rw,
                          input logic [2:0] mode, input bit bcd, input logic [15:0] count,
                          input logic [7:0] lsb, input logic [7:0] msb, input bit keep_valid);
        bit       invalid;
        int       n_ev;
        int       falls0;
        int       lat;
        bit       got;
        done_ev_t de;
        done_ev_t got_de;

        invalid = (sc == 2'd3) || (rw == 2'b00);
        n_ev    = 0;
        de.rd_data = 16'h0000;
        if (!invalid) begin
            exp_bus.push_back('{1'b0, 2'd3, op ? {sc, 6'b00_0000} : {sc, rw, mode, bcd}});
            n_ev++;
            if (rw[0]) begin
                exp_bus.push_back('{op, sc, count[7:0]});
                if (op) begin
                    pit_q.push_back(lsb);
                    de.rd_data[7:0] = lsb;
                end
                n_ev++;
            end
            if (rw[1]) begin
                exp_bus.push_back('{op, sc, count[15:8]});
                if (op) begin
                    pit_q.push_back(msb);
                    de.rd_data[15:8] = msb;
                end
                n_ev++;
            end
        end
        de.lat = invalid ? 1 : 1 + n_ev * int'(CYC);
        de.err = invalid;
        exp_done.push_back(de);
        falls0 = cs_falls;

        bus_if.req_valid   = 1'b1;
        bus_if.req_op      = op;
        bus_if.req_counter = sc;
        bus_if.req_rw      = rw;
        bus_if.req_mode    = mode;
        bus_if.req_bcd     = bcd;
        bus_if.req_count   = count;
        @(negedge clock);
        check("ready_before_accept", 32'(bus_if.req_ready), 32'd1);
        @(posedge clock);
        #1;
        if (!keep_valid) bus_if.req_valid = 1'b0;

        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(negedge clock);
            lat++;
            if (bus_if.done) got = 1'b1;
        end
        check("done_seen", 32'(got), 32'd1);
        got_de = exp_done.pop_front();
        if (got) begin
            check("done_latency", lat, got_de.lat);
            check("err", 32'(bus_if.err), 32'(got_de.err));
            check("rd_data", 32'(bus_if.rd_data), 32'(got_de.rd_data));
            check("ready_during_done", 32'(bus_if.req_ready), 32'd0);
        end
        check("bus_cycles", cs_falls - falls0, n_ev);
        check("bus_events_left", exp_bus.size(), 0);
        exp_bus.delete();
        pit_q.delete();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int  lat;
        bit  saw_done;

        bus_if.req_valid   = 1'b0;
        bus_if.req_op      = 1'b0;
        bus_if.req_counter = 2'd0;
        bus_if.req_rw      = 2'd0;
        bus_if.req_mode    = 3'd0;
        bus_if.req_bcd     = 1'b0;
        bus_if.req_count   = 16'h0000;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_cs_n", 32'(bus_if.pit_chip_select_n), 32'd1);
        check("rst_rd_n", 32'(bus_if.pit_read_enable_n), 32'd1);
        check("rst_wr_n", 32'(bus_if.pit_write_enable_n), 32'd1);
        check("rst_address", 32'(bus_if.pit_address), 32'd0);
        check("rst_data_out", 32'(bus_if.pit_data_out), 32'd0);
        check("rst_done", 32'(bus_if.done), 32'd0);
        check("rst_err", 32'(bus_if.err), 32'd0);
        check("rst_rd_data", 32'(bus_if.rd_data), 32'd0);
        check("rst_ready_low", 32'(bus_if.req_ready), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_reset", 32'(bus_if.req_ready), 32'd1);
        @(posedge clock);
        #1;

        // PROGRAM SC=0 RW=11 M=3 -> 36, 34, 12; done at 16.
        do_req(1'b0, 2'd0, 2'b11, 3'd3, 1'b0, 16'h1234, 8'h00, 8'h00, 1'b0);
        // LATCH_READ SC=2 RW=11 -> 80 then reads CD, AB.
        do_req(1'b1, 2'd2, 2'b11, 3'd0, 1'b0, 16'h0000, 8'hCD, 8'hAB, 1'b0);
        // PROGRAM SC=1 RW=10 -> 60, 55; done at 11.
        do_req(1'b0, 2'd1, 2'b10, 3'd0, 1'b0, 16'h5500, 8'h00, 8'h00, 1'b0);
        // Invalid counter and invalid RW.
        do_req(1'b0, 2'd3, 2'b11, 3'd2, 1'b0, 16'hBEEF, 8'h00, 8'h00, 1'b0);
        do_req(1'b1, 2'd0, 2'b00, 3'd0, 1'b0, 16'h0000, 8'h11, 8'h22, 1'b0);
        // Single-byte latched reads.
        do_req(1'b1, 2'd1, 2'b01, 3'd0, 1'b0, 16'h0000, 8'h5A, 8'h00, 1'b0);
        do_req(1'b1, 2'd0, 2'b10, 3'd0, 1'b0, 16'h0000, 8'h00, 8'h77, 1'b0);

        // Reset during the strobe of the second byte.
        exp_bus.push_back('{1'b0, 2'd3, 8'h36});
        exp_bus.push_back('{1'b0, 2'd0, 8'h34});
        bus_if.req_valid   = 1'b1;
        bus_if.req_op      = 1'b0;
        bus_if.req_counter = 2'd0;
        bus_if.req_rw      = 2'b11;
        bus_if.req_mode    = 3'd3;
        bus_if.req_bcd     = 1'b0;
        bus_if.req_count   = 16'h1234;
        @(posedge clock);
        #1;
        bus_if.req_valid = 1'b0;
        lat = 0;
        repeat (2 + CYC) begin
            @(negedge clock);
            lat++;
        end
        check("abort_wr_low", 32'(bus_if.pit_write_enable_n), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("abort_cs_n", 32'(bus_if.pit_chip_select_n), 32'd1);
        check("abort_rd_n", 32'(bus_if.pit_read_enable_n), 32'd1);
        check("abort_wr_n", 32'(bus_if.pit_write_enable_n), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("abort_ready", 32'(bus_if.req_ready), 32'd1);
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (bus_if.done) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        check("abort_events_left", exp_bus.size(), 0);
        exp_bus.delete();
        @(posedge clock);
        #1;

        // Back-to-back with req_valid held high.
        do_req(1'b0, 2'd2, 2'b01, 3'd2, 1'b1, 16'h00FF, 8'h00, 8'h00, 1'b1);
        do_req(1'b1, 2'd0, 2'b11, 3'd0, 1'b0, 16'h0000, 8'h3C, 8'hC3, 1'b0);

        repeat (3) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
